// File: rtl/aud_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aud_pkg
// Purpose  : Shared state encoding, slot index type and slot-base helper
// Revision : 1.0 - initial multi-slot release
// ============================================================================
package aud_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_I2C        = 3'd1,
    ST_RECD       = 3'd2,
    ST_RECD_PAUSE = 3'd3,
    ST_PLAY       = 3'd4,
    ST_PLAY_PAUSE = 3'd5
  } state_t;

  // Wide enough for any sane slot count; callers cast down to SLOT_W.
  typedef logic [15:0] slot_idx_t;

  localparam int STATE_W = 3;

  function automatic int slot_w(input int num_slots);
    return (num_slots > 1) ? $clog2(num_slots) : 1;
  endfunction

  // Slots split the address space evenly, so base is the index in the top bits.
  function automatic logic [63:0] slot_base(input slot_idx_t slot,
                                            input int addr_w,
                                            input int num_slots);
    return 64'(slot) << (addr_w - $clog2(num_slots));
  endfunction

endpackage
`default_nettype wire

// File: rtl/aud_session_if.sv
`default_nettype none
// ============================================================================
// Module   : aud_session_if
// Purpose  : Command/status bundle between key inputs, datapath and controller
// Revision : 1.0 - initial multi-slot release
// ============================================================================
interface aud_session_if #(
  parameter int ADDR_W    = 20,
  parameter int NUM_SLOTS = 4
);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic              i_start;
  logic              i_pause;
  logic              i_stop;
  logic              i_rec_play;
  logic [SLOT_W-1:0] i_slot;
  logic              i_i2c_finished;
  logic [ADDR_W-1:0] i_rec_addr;
  logic [ADDR_W-1:0] i_play_addr;

  logic              o_i2c_start;
  logic              o_rec_en;
  logic              o_play_en;
  logic              o_sel_rec;
  logic [ADDR_W-1:0] o_slot_base;
  logic [ADDR_W-1:0] o_slot_end;
  logic [2:0]        o_state;
  logic              o_empty_err;

  modport master (
    output i_start, i_pause, i_stop, i_rec_play, i_slot, i_i2c_finished,
           i_rec_addr, i_play_addr,
    input  o_i2c_start, o_rec_en, o_play_en, o_sel_rec, o_slot_base,
           o_slot_end, o_state, o_empty_err
  );

  modport slave (
    input  i_start, i_pause, i_stop, i_rec_play, i_slot, i_i2c_finished,
           i_rec_addr, i_play_addr,
    output o_i2c_start, o_rec_en, o_play_en, o_sel_rec, o_slot_base,
           o_slot_end, o_state, o_empty_err
  );

endinterface
`default_nettype wire

// File: rtl/aud_slot_table.sv
`default_nettype none
// ============================================================================
// Module   : aud_slot_table
// Purpose  : Per-slot (valid, end address) store; one write, one read port
// Revision : 1.0 - initial multi-slot release
// ============================================================================
module aud_slot_table #(
  parameter int ADDR_W    = 20,
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [ADDR_W-1:0] wr_end,
  input  logic [SLOT_W-1:0] rd_slot,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_end
);

  logic [NUM_SLOTS-1:0] valid;
  logic [ADDR_W-1:0]    end_addr [NUM_SLOTS];

  // Compare-based decode keeps a 1-slot build free of out-of-range indexing.
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    always_ff @(posedge clk) begin
      if (rst) begin
        valid[i]    <= 1'b0;
        end_addr[i] <= '0;
      end else if (wr_en && (wr_slot == SLOT_W'(i))) begin
        valid[i]    <= 1'b1;
        end_addr[i] <= wr_end;
      end
    end
  end

  always_comb begin
    rd_valid = 1'b0;
    rd_end   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (rd_slot == SLOT_W'(i)) begin
        rd_valid = valid[i];
        rd_end   = end_addr[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/aud_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aud_session_ctrl
// Purpose  : Multi-slot record/playback session FSM with pause states
// Revision : 1.0 - initial multi-slot release
// ============================================================================
module aud_session_ctrl
  import aud_pkg::*;
#(
  parameter int ADDR_W    = 20,
  parameter int NUM_SLOTS = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  aud_session_if.slave  bus
);

  localparam int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int OFFSET_W   = ADDR_W - $clog2(NUM_SLOTS);
  localparam logic [ADDR_W-1:0] SLOT_SPAN = ADDR_W'((64'd1 << OFFSET_W) - 64'd1);

  state_t            state, next_state;
  logic [SLOT_W-1:0] slot;
  logic [ADDR_W-1:0] slot_base_q, slot_end_q;
  logic              i2c_start_q, rec_en_q, play_en_q, sel_rec_q, empty_err_q;

  logic              latch, wr_en, empty_err;
  logic [SLOT_W-1:0] rd_slot;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_end;
  logic [ADDR_W-1:0] new_base;
  logic              rec_at_limit, play_at_end;

  // In IDLE the table is looked up with the incoming slot so start can decide.
  assign rd_slot      = (state == ST_IDLE) ? bus.i_slot : slot;
  assign new_base     = ADDR_W'(slot_base(slot_idx_t'(bus.i_slot), ADDR_W, NUM_SLOTS));
  assign rec_at_limit = (bus.i_rec_addr == (slot_base_q | SLOT_SPAN));
  assign play_at_end  = (bus.i_play_addr == slot_end_q);

  aud_slot_table #(
    .ADDR_W    (ADDR_W),
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_slot_table (
    .clk      (i_clk),
    .rst      (i_rst),
    .wr_en    (wr_en),
    .wr_slot  (slot),
    .wr_end   (bus.i_rec_addr),
    .rd_slot  (rd_slot),
    .rd_valid (rd_valid),
    .rd_end   (rd_end)
  );

  always_comb begin
    next_state = state;
    latch      = 1'b0;
    wr_en      = 1'b0;
    empty_err  = 1'b0;
    case (state)
      ST_I2C: if (bus.i_i2c_finished) next_state = ST_IDLE;
      ST_IDLE: begin
        if (bus.i_start) begin
          latch = 1'b1;
          if (bus.i_rec_play)  next_state = ST_RECD;
          else if (!rd_valid)  empty_err  = 1'b1;
          else                 next_state = ST_PLAY;
        end
      end
      ST_RECD: begin
        // Reaching the slot limit wins over a simultaneous pause.
        if (bus.i_stop || rec_at_limit) begin
          next_state = ST_IDLE;
          wr_en      = 1'b1;
        end else if (bus.i_pause) begin
          next_state = ST_RECD_PAUSE;
        end
      end
      ST_RECD_PAUSE: begin
        if (bus.i_stop) begin
          next_state = ST_IDLE;
          wr_en      = 1'b1;
        end else if (!bus.i_pause && bus.i_start) begin
          next_state = ST_RECD;
        end
      end
      ST_PLAY: begin
        if (bus.i_stop || play_at_end) next_state = ST_IDLE;
        else if (bus.i_pause)          next_state = ST_PLAY_PAUSE;
      end
      ST_PLAY_PAUSE: begin
        if (bus.i_stop)                          next_state = ST_IDLE;
        else if (!bus.i_pause && bus.i_start)    next_state = ST_PLAY;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_I2C;
      slot        <= '0;
      slot_base_q <= '0;
      slot_end_q  <= '0;
      i2c_start_q <= 1'b1;
      rec_en_q    <= 1'b0;
      play_en_q   <= 1'b0;
      sel_rec_q   <= 1'b0;
      empty_err_q <= 1'b0;
    end else begin
      state <= next_state;
      if (latch) begin
        slot        <= bus.i_slot;
        slot_base_q <= new_base;
        slot_end_q  <= bus.i_rec_play ? (new_base | SLOT_SPAN) : rd_end;
      end
      if (wr_en) slot_end_q <= bus.i_rec_addr;
      i2c_start_q <= (next_state == ST_I2C);
      rec_en_q    <= (next_state == ST_RECD);
      play_en_q   <= (next_state == ST_PLAY);
      sel_rec_q   <= (next_state == ST_RECD) || (next_state == ST_RECD_PAUSE);
      empty_err_q <= empty_err;
    end
  end

  assign bus.o_state     = state;
  assign bus.o_slot_base = slot_base_q;
  assign bus.o_slot_end  = slot_end_q;
  assign bus.o_i2c_start = i2c_start_q;
  assign bus.o_rec_en    = rec_en_q;
  assign bus.o_play_en   = play_en_q;
  assign bus.o_sel_rec   = sel_rec_q;
  assign bus.o_empty_err = empty_err_q;

endmodule
`default_nettype wire

// File: tb/tb_aud_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aud_session_ctrl
// Purpose  : Directed self-checking bench for the audio session controller
// Revision : 1.0 - initial multi-slot release
// ============================================================================
module tb_aud_session_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  aud_session_if #(.ADDR_W(20), .NUM_SLOTS(4)) bus ();

  aud_session_ctrl #(.ADDR_W(20), .NUM_SLOTS(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic p, input logic t);
    bus.i_start = s;
    bus.i_pause = p;
    bus.i_stop  = t;
    tick();
    bus.i_start = 1'b0;
    bus.i_pause = 1'b0;
    bus.i_stop  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (bus.o_state !== 3'd1) begin fails++; $display("FAIL reset_state: got %0d want 1", bus.o_state); end
    checks++; if (bus.o_i2c_start !== 1'b1) begin fails++; $display("FAIL reset_i2c_start: got %b want 1", bus.o_i2c_start); end
    checks++; if ({bus.o_rec_en, bus.o_play_en, bus.o_sel_rec, bus.o_empty_err} !== 4'b0000) begin
      fails++; $display("FAIL reset_enables: got %b want 0000", {bus.o_rec_en, bus.o_play_en, bus.o_sel_rec, bus.o_empty_err}); end
    checks++; if ({bus.o_slot_base, bus.o_slot_end} !== 40'd0) begin
      fails++; $display("FAIL reset_addrs: got base %h end %h want 0 0", bus.o_slot_base, bus.o_slot_end); end
    for (int i = 0; i < 8; i++) tick();
    pulse(1'b1, 1'b0, 1'b0);
    tick();
    checks++; if (bus.o_state !== 3'd1 || bus.o_i2c_start !== 1'b1) begin
      fails++; $display("FAIL i2c_hold: got state %0d i2c %b want 1 1", bus.o_state, bus.o_i2c_start); end
    bus.i_i2c_finished = 1'b1;
    tick();
    checks++; if (bus.o_state !== 3'd0 || bus.o_i2c_start !== 1'b0) begin
      fails++; $display("FAIL i2c_done: got state %0d i2c %b want 0 0", bus.o_state, bus.o_i2c_start); end
  endtask

  task automatic test_empty_play();
    bus.i_slot = 2'd2; bus.i_rec_play = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    checks++; if (bus.o_state !== 3'd0 || bus.o_empty_err !== 1'b1 || bus.o_play_en !== 1'b0) begin
      fails++; $display("FAIL empty_play: got state %0d err %b play %b want 0 1 0", bus.o_state, bus.o_empty_err, bus.o_play_en); end
    tick();
    checks++; if (bus.o_empty_err !== 1'b0) begin fails++; $display("FAIL empty_err_width: got %b want 0", bus.o_empty_err); end
  endtask

  task automatic test_record_play();
    bus.i_slot = 2'd1; bus.i_rec_play = 1'b1; bus.i_rec_addr = 20'h40000;
    pulse(1'b1, 1'b0, 1'b0);
    checks++; if (bus.o_state !== 3'd2 || bus.o_rec_en !== 1'b1 || bus.o_sel_rec !== 1'b1) begin
      fails++; $display("FAIL rec_start: got state %0d rec %b sel %b want 2 1 1", bus.o_state, bus.o_rec_en, bus.o_sel_rec); end
    checks++; if (bus.o_slot_base !== 20'h40000) begin fails++; $display("FAIL rec_base: got %h want 40000", bus.o_slot_base); end
    bus.i_rec_addr = 20'h40100;
    tick();
    checks++; if (bus.o_state !== 3'd2) begin fails++; $display("FAIL rec_run: got %0d want 2", bus.o_state); end
    bus.i_rec_addr = 20'h40123;
    pulse(1'b0, 1'b0, 1'b1);
    checks++; if (bus.o_state !== 3'd0 || bus.o_sel_rec !== 1'b0 || bus.o_slot_end !== 20'h40123) begin
      fails++; $display("FAIL rec_stop: got state %0d sel %b end %h want 0 0 40123", bus.o_state, bus.o_sel_rec, bus.o_slot_end); end
    bus.i_rec_play = 1'b0; bus.i_play_addr = 20'h40000;
    pulse(1'b1, 1'b0, 1'b0);
    checks++; if (bus.o_state !== 3'd4 || bus.o_play_en !== 1'b1 || bus.o_slot_end !== 20'h40123) begin
      fails++; $display("FAIL play_start: got state %0d play %b end %h want 4 1 40123", bus.o_state, bus.o_play_en, bus.o_slot_end); end
    bus.i_play_addr = 20'h40122;
    tick();
    checks++; if (bus.o_state !== 3'd4) begin fails++; $display("FAIL play_run: got %0d want 4", bus.o_state); end
    bus.i_play_addr = 20'h40123;
    tick();
    checks++; if (bus.o_state !== 3'd0 || bus.o_play_en !== 1'b0) begin
      fails++; $display("FAIL play_end: got state %0d play %b want 0 0", bus.o_state, bus.o_play_en); end
  endtask

  task automatic test_slot_limit();
    bus.i_slot = 2'd3; bus.i_rec_play = 1'b1; bus.i_rec_addr = 20'hC0000;
    pulse(1'b1, 1'b0, 1'b0);
    checks++; if (bus.o_slot_base !== 20'hC0000) begin fails++; $display("FAIL s3_base: got %h want C0000", bus.o_slot_base); end
    bus.i_rec_addr = 20'hFFFFE;
    tick();
    checks++; if (bus.o_state !== 3'd2) begin fails++; $display("FAIL s3_near_limit: got %0d want 2", bus.o_state); end
    bus.i_rec_addr = 20'hFFFFF;
    tick();
    checks++; if (bus.o_state !== 3'd0 || bus.o_slot_end !== 20'hFFFFF) begin
      fails++; $display("FAIL s3_limit: got state %0d end %h want 0 FFFFF", bus.o_state, bus.o_slot_end); end
    bus.i_rec_addr = 20'h0; bus.i_rec_play = 1'b0; bus.i_play_addr = 20'h0;
    pulse(1'b1, 1'b0, 1'b0);
    checks++; if (bus.o_state !== 3'd4 || bus.o_slot_end !== 20'hFFFFF) begin
      fails++; $display("FAIL s3_replay: got state %0d end %h want 4 FFFFF", bus.o_state, bus.o_slot_end); end
    pulse(1'b0, 1'b0, 1'b1);
    bus.i_slot = 2'd1;
    pulse(1'b1, 1'b0, 1'b0);
    checks++; if (bus.o_state !== 3'd4 || bus.o_slot_end !== 20'h40123) begin
      fails++; $display("FAIL s1_untouched: got state %0d end %h want 4 40123", bus.o_state, bus.o_slot_end); end
    pulse(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_pause_resume();
    bus.i_slot = 2'd1; bus.i_rec_play = 1'b0; bus.i_play_addr = 20'h0;
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    checks++; if (bus.o_state !== 3'd5 || bus.o_play_en !== 1'b0) begin
      fails++; $display("FAIL play_pause: got state %0d play %b want 5 0", bus.o_state, bus.o_play_en); end
    pulse(1'b1, 1'b0, 1'b0);
    checks++; if (bus.o_state !== 3'd4 || bus.o_play_en !== 1'b1) begin
      fails++; $display("FAIL play_resume: got state %0d play %b want 4 1", bus.o_state, bus.o_play_en); end
    bus.i_slot = 2'd3; bus.i_rec_play = 1'b1;
    tick();
    checks++; if (bus.o_state !== 3'd4 || bus.o_slot_base !== 20'h40000) begin
      fails++; $display("FAIL slot_ignored: got state %0d base %h want 4 40000", bus.o_state, bus.o_slot_base); end
    pulse(1'b0, 1'b1, 1'b1);
    checks++; if (bus.o_state !== 3'd0) begin fails++; $display("FAIL pause_stop: got %0d want 0", bus.o_state); end
    bus.i_slot = 2'd0; bus.i_rec_addr = 20'h0;
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    checks++; if (bus.o_state !== 3'd3 || bus.o_rec_en !== 1'b0 || bus.o_sel_rec !== 1'b1) begin
      fails++; $display("FAIL rec_pause: got state %0d rec %b sel %b want 3 0 1", bus.o_state, bus.o_rec_en, bus.o_sel_rec); end
    pulse(1'b1, 1'b1, 1'b0);
    checks++; if (bus.o_state !== 3'd3) begin fails++; $display("FAIL pause_over_start: got %0d want 3", bus.o_state); end
    pulse(1'b1, 1'b0, 1'b0);
    checks++; if (bus.o_state !== 3'd2 || bus.o_rec_en !== 1'b1) begin
      fails++; $display("FAIL rec_resume: got state %0d rec %b want 2 1", bus.o_state, bus.o_rec_en); end
    bus.i_rec_addr = 20'h00010;
    pulse(1'b0, 1'b0, 1'b1);
    checks++; if (bus.o_state !== 3'd0 || bus.o_slot_end !== 20'h00010) begin
      fails++; $display("FAIL rec0_stop: got state %0d end %h want 0 00010", bus.o_state, bus.o_slot_end); end
    pulse(1'b1, 1'b0, 1'b0);
    bus.i_rec_addr = 20'h3FFFF;
    pulse(1'b0, 1'b1, 1'b0);
    checks++; if (bus.o_state !== 3'd0 || bus.o_slot_end !== 20'h3FFFF) begin
      fails++; $display("FAIL limit_over_pause: got state %0d end %h want 0 3FFFF", bus.o_state, bus.o_slot_end); end
  endtask

  task automatic test_reset_mid_record();
    bus.i_slot = 2'd1; bus.i_rec_play = 1'b1; bus.i_rec_addr = 20'h0;
    pulse(1'b1, 1'b0, 1'b0);
    checks++; if (bus.o_state !== 3'd2) begin fails++; $display("FAIL pre_rst_rec: got %0d want 2", bus.o_state); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.o_state !== 3'd1 || bus.o_sel_rec !== 1'b0 || bus.o_rec_en !== 1'b0 || bus.o_i2c_start !== 1'b1) begin
      fails++; $display("FAIL mid_rst: got state %0d sel %b rec %b i2c %b want 1 0 0 1",
                        bus.o_state, bus.o_sel_rec, bus.o_rec_en, bus.o_i2c_start); end
    tick();
    bus.i_rec_play = 1'b0;
    for (int s = 0; s < 4; s++) begin
      bus.i_slot = 2'(s);
      pulse(1'b1, 1'b0, 1'b0);
      checks++; if (bus.o_state !== 3'd0 || bus.o_empty_err !== 1'b1) begin
        fails++; $display("FAIL cleared_slot%0d: got state %0d err %b want 0 1", s, bus.o_state, bus.o_empty_err); end
      tick();
    end
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_pause = 1'b0; bus.i_stop = 1'b0;
    bus.i_rec_play = 1'b0; bus.i_slot = '0; bus.i_i2c_finished = 1'b0;
    bus.i_rec_addr = '0; bus.i_play_addr = '0;
    test_reset();
    test_empty_play();
    test_record_play();
    test_slot_limit();
    test_pause_resume();
    test_reset_mid_record();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
